// File: rtl/sprite_pkg.sv
// Shared types for the falling-sprite address generator: FSM states, the
// per-kind sprite geometry table and its lookup helpers.
package sprite_pkg;

    typedef enum logic [1:0] {
        SPAWN,
        FALL,
        LAND
    } state_t;

    typedef struct packed {
        logic [6:0]  w;
        logic [5:0]  h;
        logic [13:0] base;
    } kind_info_t;

    localparam kind_info_t KIND_TABLE [8] = '{
        '{w: 7'd80, h: 6'd20, base: 14'd0},
        '{w: 7'd60, h: 6'd40, base: 14'd1600},
        '{w: 7'd60, h: 6'd40, base: 14'd4000},
        '{w: 7'd40, h: 6'd40, base: 14'd6400},
        '{w: 7'd60, h: 6'd40, base: 14'd8000},
        '{w: 7'd60, h: 6'd40, base: 14'd10400},
        '{w: 7'd60, h: 6'd40, base: 14'd12800},
        '{w: 7'd60, h: 6'd40, base: 14'd12800}
    };

    // Kinds beyond the table reuse the last entry.
    function automatic kind_info_t kind_lookup(input int unsigned idx);
        logic [2:0] sel;
        sel = (idx > 32'd7) ? 3'd7 : idx[2:0];
        return KIND_TABLE[sel];
    endfunction

    function automatic int centre_x(input int x0, input int fw, input int w);
        return x0 + (fw - w) / 2;
    endfunction

endpackage

// File: rtl/sprite_addr_calc.sv
// Combinational pixel classifier: border, sprite texel or playfield background,
// producing the block-ROM address for the current pixel.
module sprite_addr_calc
    import sprite_pkg::*;
#(
    parameter int FIELD_X0   = 220,
    parameter int FIELD_W    = 200,
    parameter int FIELD_H    = 400,
    parameter int ADDR_W     = 17,
    parameter int WHITE_ADDR = 18000,
    parameter int BLACK_ADDR = 16400
) (
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic [10:0]       pos_x,
    input  logic [10:0]       pos_y,
    input  kind_info_t        info,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [10:0] FX0 = 11'(FIELD_X0);
    localparam logic [10:0] FXE = 11'(FIELD_X0 + FIELD_W);
    localparam logic [10:0] FH  = 11'(FIELD_H);

    logic [10:0] h_pos;
    logic [10:0] v_pos;
    logic [10:0] box_w;
    logic [10:0] box_h;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [12:0] row_off;
    logic        outside;
    logic        in_box;

    always_comb begin
        h_pos   = {1'b0, h_cnt};
        v_pos   = {1'b0, v_cnt};
        box_w   = 11'(info.w);
        box_h   = 11'(info.h);
        dx      = h_pos - pos_x;
        dy      = v_pos - pos_y;
        // Only meaningful inside the box, where dy < 40 keeps this within 13 bits.
        row_off = 13'(info.w) * 13'(dy);
        outside = (h_pos < FX0) || (h_pos >= FXE) || (v_pos >= FH);
        in_box  = (h_pos >= pos_x) && (h_pos < pos_x + box_w) &&
                  (v_pos >= pos_y) && (v_pos < pos_y + box_h);
        if (outside)
            addr = ADDR_W'(BLACK_ADDR);
        else if (in_box)
            addr = ADDR_W'(info.base) + ADDR_W'(dx) + ADDR_W'(row_off);
        else
            addr = ADDR_W'(WHITE_ADDR);
    end

endmodule

// File: rtl/falling_sprite_addr_gen.sv
// Falling-sprite FSM, position registers and registered ROM address.
// Optional sideways movement is built only when SPRITE_HMOVE_EN is defined.
module falling_sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int FIELD_X0   = 220,
    parameter int FIELD_W    = 200,
    parameter int FIELD_H    = 400,
    parameter int STEP_Y     = 20,
    parameter int STEP_X     = 20,
    parameter int KIND_W     = 3,
    parameter int ADDR_W     = 17,
    parameter int WHITE_ADDR = 18000,
    parameter int BLACK_ADDR = 16400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              frame_tick,
    input  logic              pause,
    input  logic [KIND_W-1:0] kind_in,
    input  logic              move_left,
    input  logic              move_right,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              landed,
    output logic [9:0]        sprite_x,
    output logic [9:0]        sprite_y
);

    localparam logic [10:0] FH      = 11'(FIELD_H);
    localparam logic [10:0] SY      = 11'(STEP_Y);
    localparam logic [10:0] X_RESET = 11'(centre_x(FIELD_X0, FIELD_W, int'(KIND_TABLE[0].w)));

    state_t            state_reg;
    logic [KIND_W-1:0] kind_q_reg;
    logic [10:0]       x_reg;
    logic [10:0]       y_reg;
    logic [ADDR_W-1:0] pixel_addr_reg;
    logic              landed_reg;

    kind_info_t        cur_info;
    kind_info_t        spawn_info;
    logic [10:0]       cur_h;
    logic [10:0]       spawn_x;
    logic [10:0]       x_next;
    logic [ADDR_W-1:0] addr_next;
    logic              qual_tick;

    assign cur_info   = kind_lookup(32'(kind_q_reg));
    assign spawn_info = kind_lookup(32'(kind_in));
    assign cur_h      = 11'(cur_info.h);
    assign spawn_x    = 11'(centre_x(FIELD_X0, FIELD_W, int'(spawn_info.w)));
    assign qual_tick  = frame_tick & ~pause;

`ifdef SPRITE_HMOVE_EN
    localparam logic [10:0] FX0 = 11'(FIELD_X0);
    localparam logic [10:0] FXE = 11'(FIELD_X0 + FIELD_W);
    localparam logic [10:0] SX  = 11'(STEP_X);

    // A shift that would leave the playfield is dropped, not clamped.
    always_comb begin
        x_next = x_reg;
        if (move_left && !move_right && (x_reg >= FX0 + SX))
            x_next = x_reg - SX;
        else if (move_right && !move_left && (x_reg + 11'(cur_info.w) + SX <= FXE))
            x_next = x_reg + SX;
    end
`else
    logic unused_moves;
    assign unused_moves = move_left ^ move_right;
    assign x_next       = x_reg;
`endif

    sprite_addr_calc #(
        .FIELD_X0  (FIELD_X0),
        .FIELD_W   (FIELD_W),
        .FIELD_H   (FIELD_H),
        .ADDR_W    (ADDR_W),
        .WHITE_ADDR(WHITE_ADDR),
        .BLACK_ADDR(BLACK_ADDR)
    ) u_addr_calc (
        .h_cnt(h_cnt),
        .v_cnt(v_cnt),
        .pos_x(x_reg),
        .pos_y(y_reg),
        .info (cur_info),
        .addr (addr_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= SPAWN;
            kind_q_reg     <= '0;
            x_reg          <= X_RESET;
            y_reg          <= '0;
            pixel_addr_reg <= ADDR_W'(BLACK_ADDR);
            landed_reg     <= 1'b0;
        end else begin
            pixel_addr_reg <= addr_next;
            landed_reg     <= 1'b0;
            case (state_reg)
                SPAWN: begin
                    kind_q_reg <= kind_in;
                    y_reg      <= '0;
                    x_reg      <= spawn_x;
                    state_reg  <= FALL;
                end
                FALL: begin
                    if (qual_tick) begin
                        x_reg <= x_next;
                        // landed is raised together with the move into LAND so it spans that cycle.
                        if (y_reg + cur_h + SY > FH) begin
                            y_reg      <= FH - cur_h;
                            state_reg  <= LAND;
                            landed_reg <= 1'b1;
                        end else begin
                            y_reg <= y_reg + SY;
                        end
                    end
                end
                LAND:    state_reg <= SPAWN;
                default: state_reg <= SPAWN;
            endcase
        end
    end

    logic unused_pos_msbs;
    assign unused_pos_msbs = x_reg[10] ^ y_reg[10];

    assign pixel_addr = pixel_addr_reg;
    assign landed     = landed_reg;
    assign sprite_x   = x_reg[9:0];
    assign sprite_y   = y_reg[9:0];

endmodule

// File: tb/tb_falling_sprite_addr_gen.sv
// Self-checking bench for falling_sprite_addr_gen: pixel-address vector table,
// directed fall/shift/pause/reset sequences and a randomized run against a model.
module tb_falling_sprite_addr_gen;

    localparam int FX0   = 220;
    localparam int FW    = 200;
    localparam int FH    = 400;
    localparam int SY    = 20;
    localparam int SX    = 20;
    localparam int WHITE = 18000;
    localparam int BLACK = 16400;

    int kw[8] = '{80, 60, 60, 40, 60, 60, 60, 60};
    int kh[8] = '{20, 40, 40, 40, 40, 40, 40, 40};
    int kb[8] = '{0, 1600, 4000, 6400, 8000, 10400, 12800, 12800};

`ifdef SPRITE_HMOVE_EN
    int exp_left[4] = '{270, 250, 230, 230};
`else
    int exp_left[4] = '{290, 290, 290, 290};
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        frame_tick;
    logic        pause;
    logic [2:0]  kind_in;
    logic        move_left;
    logic        move_right;
    logic [16:0] pixel_addr;
    logic        landed;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 = spawning, 1 = falling, 2 = landed.
    int m_phase, m_kind, m_x, m_y, m_addr;

    typedef struct {
        int h;
        int v;
        int addr;
    } vec_t;
    vec_t vecs[12];

    falling_sprite_addr_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .frame_tick(frame_tick),
        .pause     (pause),
        .kind_in   (kind_in),
        .move_left (move_left),
        .move_right(move_right),
        .pixel_addr(pixel_addr),
        .landed    (landed),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_addr(input int h, input int v);
        int w, hh;
        w  = kw[m_kind];
        hh = kh[m_kind];
        if (h < FX0 || h >= FX0 + FW || v >= FH) return BLACK;
        if (h >= m_x && h < m_x + w && v >= m_y && v < m_y + hh)
            return kb[m_kind] + (h - m_x) + w * (v - m_y);
        return WHITE;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_addr  = BLACK;
            m_phase = 0;
            m_kind  = 0;
            m_y     = 0;
            m_x     = FX0 + (FW - kw[0]) / 2;
            return;
        end
        m_addr = ref_addr(int'(h_cnt), int'(v_cnt));
        case (m_phase)
            0: begin
                m_kind  = int'(kind_in);
                m_y     = 0;
                m_x     = FX0 + (FW - kw[m_kind]) / 2;
                m_phase = 1;
            end
            1: begin
                if (frame_tick && !pause) begin
`ifdef SPRITE_HMOVE_EN
                    if (move_left && !move_right && m_x - SX >= FX0)
                        m_x = m_x - SX;
                    else if (move_right && !move_left && m_x + kw[m_kind] + SX <= FX0 + FW)
                        m_x = m_x + SX;
`endif
                    if (m_y + kh[m_kind] + SY > FH) begin
                        m_y     = FH - kh[m_kind];
                        m_phase = 2;
                    end else begin
                        m_y = m_y + SY;
                    end
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock: advance the model on the edge, then compare every output.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_pixel_addr", int'(pixel_addr), m_addr);
        check("model_sprite_x", int'(sprite_x), m_x);
        check("model_sprite_y", int'(sprite_y), m_y);
        check("model_landed", int'(landed), (m_phase == 2) ? 1 : 0);
    endtask

    task automatic restart(input int kind);
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        kind_in    = 3'(kind);
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{290, 5, 410};
        vecs[1]  = '{100, 5, BLACK};
        vecs[2]  = '{225, 5, WHITE};
        vecs[3]  = '{280, 0, 0};
        vecs[4]  = '{359, 19, 1599};
        vecs[5]  = '{360, 5, WHITE};
        vecs[6]  = '{280, 20, WHITE};
        vecs[7]  = '{219, 0, BLACK};
        vecs[8]  = '{420, 0, BLACK};
        vecs[9]  = '{419, 0, WHITE};
        vecs[10] = '{300, 400, BLACK};
        vecs[11] = '{300, 399, WHITE};

        rst_n      = 1'b0;
        h_cnt      = 10'd0;
        v_cnt      = 10'd0;
        frame_tick = 1'b0;
        pause      = 1'b0;
        kind_in    = 3'd3;
        move_left  = 1'b0;
        move_right = 1'b0;

        // Reset state, then kind 3 falls for 19 back-to-back ticks.
        cycle();
        check("reset_pixel_addr", int'(pixel_addr), BLACK);
        check("reset_sprite_x", int'(sprite_x), 280);
        check("reset_sprite_y", int'(sprite_y), 0);
        check("reset_landed", int'(landed), 0);
        rst_n = 1'b1;
        cycle();
        check("spawn3_x", int'(sprite_x), 300);
        frame_tick = 1'b1;
        pulses     = 0;
        for (int i = 1; i <= 19; i++) begin
            cycle();
            if (i < 19 && landed) pulses++;
        end
        check("kind3_early_landed", pulses, 0);
        check("kind3_landed", int'(landed), 1);
        check("kind3_land_y", int'(sprite_y), 360);
        $display("kind 3 landed y=%0d", sprite_y);
        frame_tick = 1'b0;
        cycle();
        check("after_land_landed", int'(landed), 0);
        cycle();

        // Address table against a kind-0 sprite at (280, 0).
        restart(0);
        for (int i = 0; i < 12; i++) begin
            h_cnt = 10'(vecs[i].h);
            v_cnt = 10'(vecs[i].v);
            cycle();
            check("vec_pixel_addr", int'(pixel_addr), vecs[i].addr);
            $display("vec %0d h=%0d v=%0d addr=%0d", i, vecs[i].h, vecs[i].v, pixel_addr);
        end

        // Kind 1 with move_left held for four ticks.
        restart(1);
        check("spawn1_x", int'(sprite_x), 290);
        frame_tick = 1'b1;
        move_left  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("left_x", int'(sprite_x), exp_left[i]);
            check("left_y", int'(sprite_y), 20 * (i + 1));
            $display("move_left tick %0d x=%0d y=%0d", i + 1, sprite_x, sprite_y);
        end

        // Both directions together: no shift, normal fall.
        move_right = 1'b1;
        cycle();
        check("both_x", int'(sprite_x), exp_left[3]);
        check("both_y", int'(sprite_y), 100);
        move_left  = 1'b0;
        move_right = 1'b0;

        // Paused ticks are ignored.
        pause = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check("pause_y", int'(sprite_y), 100);
        pause = 1'b0;
        cycle();
        check("unpause_y", int'(sprite_y), 120);

        // Reset while mid-fall at y = 200, pointing the pixel inside the sprite.
        for (int i = 0; i < 4; i++) cycle();
        check("midfall_y", int'(sprite_y), 200);
        frame_tick = 1'b0;
        h_cnt      = 10'(exp_left[3] + 5);
        v_cnt      = 10'd205;
        rst_n      = 1'b0;
        cycle();
        check("midrst_pixel_addr", int'(pixel_addr), BLACK);
        check("midrst_sprite_y", int'(sprite_y), 0);
        check("midrst_sprite_x", int'(sprite_x), 280);
        check("midrst_landed", int'(landed), 0);
        rst_n   = 1'b1;
        kind_in = 3'd3;
        cycle();
        check("midrst_spawn_x", int'(sprite_x), 300);

        // A 20-high sprite lands on the 20th tick.
        restart(0);
        frame_tick = 1'b1;
        pulses     = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (i < 20 && landed) pulses++;
        end
        check("kind0_early_landed", pulses, 0);
        check("kind0_landed", int'(landed), 1);
        check("kind0_land_y", int'(sprite_y), 380);
        $display("kind 0 landed y=%0d", sprite_y);

        // Randomized run, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 499) != 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            pause      = ($urandom_range(0, 7) == 0);
            move_left  = ($urandom_range(0, 2) == 0);
            move_right = ($urandom_range(0, 2) == 0);
            kind_in    = 3'($urandom_range(0, 7));
            h_cnt      = 10'($urandom_range(200, 440));
            v_cnt      = 10'($urandom_range(0, 420));
            cycle();
            if (landed)
                $display("random land kind=%0d x=%0d y=%0d", m_kind, sprite_x, sprite_y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/falling_sprite_addr_gen.md
# falling_sprite_addr_gen

Parametrised falling-sprite address generator for the VGA game display path. It sits between the VGA sync counters and the sprite block-ROM. Each frame tick it moves one sprite of a selectable kind down a playfield window, and can also shift it sideways. For every pixel it produces the ROM address: sprite texel, playfield background (white) or outside-field border (black). It spawns a new sprite on landing and reports each landing with a one-cycle pulse.

## Interface
- `FIELD_X0`, default 220: left edge of playfield, in h_cnt pixels
- `FIELD_W`, default 200: playfield width, pixels
- `FIELD_H`, default 400: playfield height, pixels; the playfield starts at v_cnt = 0
- `STEP_Y`, default 20: vertical fall per frame tick, pixels
- `STEP_X`, default 20: horizontal shift per accepted move, pixels
- `KIND_W`, default 3: width of the sprite-kind select
- `ADDR_W`, default 17: ROM address width
- `WHITE_ADDR`, default 18000: background texel address
- `BLACK_ADDR`, default 16400: border texel address

Ports:
- `clk`, in, 1: sole clock
- `rst_n`, in, 1: reset, synchronous, active-low
- `h_cnt`, in, 10: current pixel column
- `v_cnt`, in, 10: current pixel row
- `frame_tick`, in, 1: one-cycle pulse that advances the sprite
- `pause`, in, 1: while high, `frame_tick` is ignored
- `kind_in`, in, KIND_W: kind for the next spawn, sampled in SPAWN
- `move_left`, in, 1: shift request, acted on at `frame_tick`
- `move_right`, in, 1: shift request, acted on at `frame_tick`
- `pixel_addr`, out, ADDR_W: registered ROM address
- `landed`, out, 1: one-cycle pulse in LAND
- `sprite_x`, out, 10: current sprite left edge (registered)
- `sprite_y`, out, 10: current sprite top edge (registered)

## Operation
- Sprite table (kind → width, height, ROM base):
  - 0 → 80×20, base 0
  - 1 → 60×40, base 1600
  - 2 → 60×40, base 4000
  - 3 → 40×40, base 6400
  - 4 → 60×40, base 8000
  - 5 → 60×40, base 10400
  - 6 and 7 → 60×40, base 12800
  - Any kind index above 7 maps to the kind-7 entry.
- FSM states: SPAWN, FALL, LAND.
- SPAWN (exactly 1 cycle):
  - latch `kind_in` into `kind_q`
  - set y = 0 and x = FIELD_X0 + (FIELD_W − w)/2, using truncating division
  - go to FALL
- FALL: on `frame_tick & ~pause`:
  - If y + h + STEP_Y > FIELD_H: set y = FIELD_H − h and go to LAND.
  - Otherwise: y += STEP_Y.
- Horizontal shift happens on the same qualified tick and only in FALL:
  - `move_left` alone: x −= STEP_X if x − STEP_X ≥ FIELD_X0, else no move.
  - `move_right` alone: x += STEP_X if x + w + STEP_X ≤ FIELD_X0 + FIELD_W, else no move.
  - Both asserted, or neither: no move.
- LAND (exactly 1 cycle): `landed` = 1, then go to SPAWN. Ticks arriving in LAND or SPAWN are dropped.
- Address selection, first match wins:
  1. Pixel outside the field (h < FIELD_X0, h ≥ FIELD_X0 + FIELD_W, or v ≥ FIELD_H): BLACK_ADDR.
  2. Pixel inside the sprite box [x, x+w) × [y, y+h): base + (h − x) + w·(v − y).
  3. Otherwise: WHITE_ADDR.
- Arithmetic: all position math is unsigned, 11 bits internally so nothing wraps. The product w·(v − y) is at most 80·40 and fits in 13 bits. The final sum is zero-extended to ADDR_W.

## Timing
- `pixel_addr` lags `h_cnt`/`v_cnt` by exactly 1 clock and uses the current x/y/`kind_q`.
- A position update becomes visible on `sprite_x`/`sprite_y` and in address generation on the clock after the qualified tick.
- With defaults, a 40-high sprite reaches y = 360 after 18 ticks; the 19th tick lands it. A 20-high sprite lands on the 20th tick.
- Reset values (rst_n low at a clock edge, including mid-fall):
  - state = SPAWN, `kind_q` = 0, y = 0, x = 280
  - `pixel_addr` = BLACK_ADDR, `landed` = 0
  - The first SPAWN follows the first clock with `rst_n` high.

## Configuration
- `SPRITE_HMOVE_EN` defined: horizontal shift enabled as above.
- `SPRITE_HMOVE_EN` undefined: `move_left`/`move_right` are ignored and x stays at its SPAWN (centred) value. No shift logic is generated.

## Structure
- Package `sprite_pkg` holds:
  - the state enum
  - the kind-table typedef (width, height, base)
  - the constant 8-entry table and a lookup function
- One sub-module, `sprite_addr_calc`: pure combinational box test and address arithmetic. The top module owns the FSM and position registers, and registers the address.

## Test plan
- Reset, then `kind_in` = 3, 19 ticks → `landed` pulses once on the cycle after tick 19 with `sprite_y` = 360. Next cycle is SPAWN.
- Kind 0 at y = 0, x = 280, pixel (h = 290, v = 5) → `pixel_addr` = 10 + 80·5 = 410 one clock later. (h = 100, v = 5) → 16400. (h = 225, v = 5) → 18000.
- Kind 1 with `move_left` held for 4 ticks → x goes 290 → 270 → 250 → 230, then stays at 230 (a further shift would cross 220).
- `move_left` and `move_right` together on a tick → x unchanged, y += 20.
- `pause` high during 5 ticks → y unchanged. Release → next tick gives y += 20.
- `rst_n` low mid-fall at y = 200 → on the next clock `pixel_addr` = 16400, y = 0, state = SPAWN, `landed` stays 0.
